// File: rtl/if_id_inst_queue.sv
// rtl/if_id_inst_queue.sv - dual-issue IF->ID instruction queue (circular buffer, flushable)
module if_id_inst_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 72,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line1_in_valid_i,
    input  logic              line2_in_valid_i,
    input  logic [DATA_W-1:0] line1_in_data_i,
    input  logic [DATA_W-1:0] line2_in_data_i,
    output logic              now_allowin_o,
    input  logic [1:0]        id_pop_i,
    output logic              line1_out_valid_o,
    output logic              line2_out_valid_o,
    output logic [DATA_W-1:0] line1_out_data_o,
    output logic [DATA_W-1:0] line2_out_data_o,
    output logic [CNT_W-1:0]  queue_cnt_o,
    input  logic              excep_flush_i,
    input  logic              banch_flush_i
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_flush;
    logic              w_allowin;
    logic [1:0]        w_push;
    logic [1:0]        w_req_pop;
    logic [1:0]        w_pop;
    logic [PTR_W-1:0]  w_head1;
    logic [PTR_W-1:0]  w_tail1;

    assign w_flush   = excep_flush_i | banch_flush_i;
    // Two free slots are required so a dual push can never overrun, even without crediting pops.
    assign w_allowin = (r_cnt <= CNT_W'(DEPTH - 2));

    assign w_push    = !w_allowin        ? 2'd0 :
                       !line1_in_valid_i ? 2'd0 :
                       line2_in_valid_i  ? 2'd2 : 2'd1;

    assign w_req_pop = (id_pop_i == 2'b11) ? 2'd2 : id_pop_i;
    assign w_pop     = ({{(CNT_W-2){1'b0}}, w_req_pop} > r_cnt) ? r_cnt[1:0] : w_req_pop;

    assign w_head1   = r_head + PTR_W'(1);
    assign w_tail1   = r_tail + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push != 2'd0) begin
                r_mem[r_tail] <= line1_in_data_i;
            end
            if (w_push == 2'd2) begin
                r_mem[w_tail1] <= line2_in_data_i;
            end
            r_tail <= r_tail + PTR_W'(w_push);
            r_head <= r_head + PTR_W'(w_pop);
            r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign now_allowin_o     = w_allowin;
    assign line1_out_valid_o = (r_cnt >= CNT_W'(1));
    assign line2_out_valid_o = (r_cnt >= CNT_W'(2));
    assign line1_out_data_o  = r_mem[r_head];
    assign line2_out_data_o  = r_mem[w_head1];
    assign queue_cnt_o       = r_cnt;

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_if_id_inst_queue.sv
// tb/tb_if_id_inst_queue.sv - randomized self-checking bench for if_id_inst_queue
module tb_if_id_inst_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 72;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              line1_in_valid_i = 1'b0;
    logic              line2_in_valid_i = 1'b0;
    logic [DATA_W-1:0] line1_in_data_i = '0;
    logic [DATA_W-1:0] line2_in_data_i = '0;
    logic              now_allowin_o;
    logic [1:0]        id_pop_i = 2'd0;
    logic              line1_out_valid_o;
    logic              line2_out_valid_o;
    logic [DATA_W-1:0] line1_out_data_o;
    logic [DATA_W-1:0] line2_out_data_o;
    logic [CNT_W-1:0]  queue_cnt_o;
    logic              excep_flush_i = 1'b0;
    logic              banch_flush_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] mq[$];

    if_id_inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .line1_in_valid_i  (line1_in_valid_i),
        .line2_in_valid_i  (line2_in_valid_i),
        .line1_in_data_i   (line1_in_data_i),
        .line2_in_data_i   (line2_in_data_i),
        .now_allowin_o     (now_allowin_o),
        .id_pop_i          (id_pop_i),
        .line1_out_valid_o (line1_out_valid_o),
        .line2_out_valid_o (line2_out_valid_o),
        .line1_out_data_o  (line1_out_data_o),
        .line2_out_data_o  (line2_out_data_o),
        .queue_cnt_o       (queue_cnt_o),
        .excep_flush_i     (excep_flush_i),
        .banch_flush_i     (banch_flush_i)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    // One clock of stimulus; the reference queue then applies flush / pop / push from the pre-edge size.
    task automatic step(input logic v1, input logic v2, input logic [DATA_W-1:0] d1,
                        input logic [DATA_W-1:0] d2, input logic [1:0] pop,
                        input logic ef, input logic bf);
        int sz;
        int np;
        line1_in_valid_i = v1;
        line2_in_valid_i = v2;
        line1_in_data_i  = d1;
        line2_in_data_i  = d2;
        id_pop_i         = pop;
        excep_flush_i    = ef;
        banch_flush_i    = bf;
        @(posedge clk);
        #1;
        sz = mq.size();
        if (ef || bf) begin
            mq.delete();
        end else begin
            np = (pop == 2'd3) ? 2 : int'(pop);
            if (np > sz) np = sz;
            repeat (np) void'(mq.pop_front());
            if (sz <= DEPTH - 2 && v1) begin
                mq.push_back(d1);
                if (v2) mq.push_back(d2);
            end
        end
        line1_in_valid_i = 1'b0;
        line2_in_valid_i = 1'b0;
        id_pop_i         = 2'd0;
        excep_flush_i    = 1'b0;
        banch_flush_i    = 1'b0;
    endtask

    task automatic clear_queue();
        step(1'b0, 1'b0, '0, '0, 2'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (now_allowin_o !== 1'b1 || queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0 ||
            line2_out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: allowin=%b cnt=%0d v1=%b v2=%b, expected 1 0 0 0",
                     now_allowin_o, queue_cnt_o, line1_out_valid_o, line2_out_valid_o);
        end
        n_tests++;
        if (line1_out_data_o !== '0 || line2_out_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_data: d1=%h d2=%h, expected 0", line1_out_data_o, line2_out_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (now_allowin_o !== 1'b1 || queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0 ||
            line1_out_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: allowin=%b cnt=%0d v1=%b d1=%h, expected 1 0 0 0",
                     now_allowin_o, queue_cnt_o, line1_out_valid_o, line1_out_data_o);
        end
    endtask

    task automatic test_full_boundary();
        logic [DATA_W-1:0] a0;
        logic [DATA_W-1:0] b0;
        a0 = rnd_data();
        b0 = rnd_data();
        step(1'b1, 1'b1, a0, b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd6 || now_allowin_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_six: cnt=%0d allowin=%b, expected 6 1", queue_cnt_o, now_allowin_o);
        end
        step(1'b1, 1'b0, rnd_data(), '0, 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd7 || now_allowin_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_seven: cnt=%0d allowin=%b, expected 7 0", queue_cnt_o, now_allowin_o);
        end
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd7 || now_allowin_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drop: cnt=%0d allowin=%b, expected 7 0", queue_cnt_o, now_allowin_o);
        end
        n_tests++;
        if (line1_out_data_o !== a0 || line2_out_data_o !== b0) begin
            n_fail++;
            $display("FAIL full_head: d1=%h d2=%h, expected %h %h", line1_out_data_o, line2_out_data_o, a0, b0);
        end
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd1, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd6 || line1_out_data_o !== b0) begin
            n_fail++;
            $display("FAIL full_pop_no_push: cnt=%0d d1=%h, expected 6 %h", queue_cnt_o, line1_out_data_o, b0);
        end
        clear_queue();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, DATA_W'(2 * i), DATA_W'(2 * i + 1), 2'd0, 1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b1, DATA_W'(6 + 2 * c), DATA_W'(7 + 2 * c), 2'd2, 1'b0, 1'b0);
            n_tests++;
            if (queue_cnt_o !== 4'd6 || line1_out_data_o !== DATA_W'(2 * c + 2) ||
                line2_out_data_o !== DATA_W'(2 * c + 3)) begin
                n_fail++;
                $display("FAIL wrap_c%0d: cnt=%0d d1=%0d d2=%0d, expected 6 %0d %0d", c, queue_cnt_o,
                         line1_out_data_o, line2_out_data_o, 2 * c + 2, 2 * c + 3);
            end
        end
        clear_queue();
    endtask

    task automatic test_pop_clip();
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        x = rnd_data();
        y = rnd_data();
        step(1'b1, 1'b0, x, '0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 2'd2, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_clip: cnt=%0d v1=%b, expected 0 0", queue_cnt_o, line1_out_valid_o);
        end
        step(1'b1, 1'b0, y, '0, 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd1 || line1_out_valid_o !== 1'b1 || line2_out_valid_o !== 1'b0 ||
            line1_out_data_o !== y) begin
            n_fail++;
            $display("FAIL pop_clip_head: cnt=%0d v1=%b v2=%b d1=%h, expected 1 1 0 %h", queue_cnt_o,
                     line1_out_valid_o, line2_out_valid_o, line1_out_data_o, y);
        end
        clear_queue();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] e;
        for (int k = 0; k < 2; k++) begin
            c = rnd_data();
            d = rnd_data();
            e = rnd_data();
            step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
            step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
            step(1'b1, 1'b0, rnd_data(), '0, 2'd0, 1'b0, 1'b0);
            n_tests++;
            if (queue_cnt_o !== 4'd5) begin
                n_fail++;
                $display("FAIL flush%0d_pre: cnt=%0d, expected 5", k, queue_cnt_o);
            end
            step(1'b1, 1'b1, c, d, 2'd2, (k == 0), (k == 1));
            n_tests++;
            if (queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0 || line2_out_valid_o !== 1'b0 ||
                now_allowin_o !== 1'b1) begin
                n_fail++;
                $display("FAIL flush%0d: cnt=%0d v1=%b v2=%b allowin=%b, expected 0 0 0 1", k,
                         queue_cnt_o, line1_out_valid_o, line2_out_valid_o, now_allowin_o);
            end
            step(1'b0, 1'b0, '0, '0, 2'd0, 1'b0, 1'b0);
            step(1'b1, 1'b0, e, '0, 2'd0, 1'b0, 1'b0);
            n_tests++;
            if (queue_cnt_o !== 4'd1 || line1_out_data_o !== e || line1_out_data_o === c ||
                line2_out_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush%0d_after: cnt=%0d d1=%h v2=%b, expected 1 %h 0", k,
                         queue_cnt_o, line1_out_data_o, line2_out_valid_o, e);
            end
            clear_queue();
        end
    endtask

    task automatic test_line2_only();
        logic [DATA_W-1:0] p;
        p = rnd_data();
        step(1'b0, 1'b1, '0, rnd_data(), 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL line2_only: cnt=%0d v1=%b, expected 0 0", queue_cnt_o, line1_out_valid_o);
        end
        step(1'b1, 1'b0, p, '0, 2'd0, 1'b0, 1'b0);
        n_tests++;
        if (queue_cnt_o !== 4'd1 || line1_out_data_o !== p) begin
            n_fail++;
            $display("FAIL line1_only: cnt=%0d d1=%h, expected 1 %h", queue_cnt_o, line1_out_data_o, p);
        end
        clear_queue();
    endtask

    task automatic test_random();
        int sz;
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom), 1'($urandom), rnd_data(), rnd_data(), 2'($urandom),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0));
            sz = mq.size();
            n_tests++;
            if (queue_cnt_o !== CNT_W'(sz) || now_allowin_o !== (sz <= DEPTH - 2) ||
                line1_out_valid_o !== (sz >= 1) || line2_out_valid_o !== (sz >= 2) ||
                (sz >= 1 && line1_out_data_o !== mq[0]) || (sz >= 2 && line2_out_data_o !== mq[1])) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random_c%0d: cnt=%0d allowin=%b v1=%b v2=%b d1=%h d2=%h, expected cnt=%0d",
                             c, queue_cnt_o, now_allowin_o, line1_out_valid_o, line2_out_valid_o,
                             line1_out_data_o, line2_out_data_o, sz);
            end
        end
        clear_queue();
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, rnd_data(), rnd_data(), 2'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        n_tests++;
        if (queue_cnt_o !== 4'd0 || line1_out_valid_o !== 1'b0 || line1_out_data_o !== '0 ||
            now_allowin_o !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: cnt=%0d v1=%b d1=%h allowin=%b, expected 0 0 0 1",
                     queue_cnt_o, line1_out_valid_o, line1_out_data_o, now_allowin_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_boundary();
        test_wrap();
        test_pop_clip();
        test_flush();
        test_line2_only();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
